gpr_writeback_unit: RTL and testbench
=====================================

Name: gpr_writeback_unit

Overview:
- Producer end of the decode-stage operand interface.
- Tracks results travelling through the POST_DEC_LD post-decode pipeline stages and commits retiring results into the architectural GPR file.
- Drives the `gpr` array, plus per-stage forwarding match signals and values, to the decode phase.
- Match signals are computed against the d/s/t register indices of the micro-instruction currently at the decode queue head.

Parameters:
- POST_DEC_LD, 3, number of post-decode stages tracked; stage 0 is the youngest, stage LD-1 the oldest, and commit happens on exit from LD-1.
- REG_W, 64, GPR data width.
- REG_N, 16, number of architectural GPRs.
- IDX_W, 5, register index width.
- RIP_ADDR, 16, index denoting RIP; never written, never forwarded.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- res_valid  in  1  execute stage presents a result this cycle.
- res_idx  in  IDX_W  destination index of the result.
- res_val  in  REG_W  result value.
- res_pend  in  1  value not yet known (load); supplied later via ld_*.
- ld_valid  in  1  load data return.
- ld_stage  in  $clog2(POST_DEC_LD)  stage whose pending value is filled.
- ld_val  in  REG_W  load data.
- flush  in  1  discard the res_* capture this cycle.
- dq_d, dq_s, dq_t  in  IDX_W each  operand indices of the decode queue head.
- fwd_sig_d, fwd_sig_s, fwd_sig_t  out  POST_DEC_LD each  bit i set means stage i supplies that operand.
- fwd_val  out  POST_DEC_LD x REG_W  stage values.
- gpr  out  REG_N x REG_W  architectural register file.
- hazard  out  1  (only with FWD_SCOREBOARD_EN) decode must stall.

Behaviour:
- Reset (rstn low, async): all stage valid and pend bits cleared, all `gpr` entries 0, `fwd_val` 0, `fwd_sig_*` 0, `hazard` 0.
- Each stage holds {valid, idx, val, pend}. Every clock, stage i+1 takes stage i.
- Stage 0 capture:
  - Takes {res_valid & ~flush & (res_idx != RIP_ADDR) & (res_idx < REG_N), res_idx, res_val, res_pend}.
  - An invalid capture is a bubble: valid=0, val=0.
- Commit: if stage LD-1 is valid and not pending, `gpr[idx]` gets its val on the same clock edge that shifts it out. The value is visible on `gpr` one cycle after the edge.
- Pending commit: a stage LD-1 entry still pending at the shift is an error. Its commit is dropped, and assertion `wb_pend_at_commit` fires in simulation.
- Load fill: if ld_valid is set, stage ld_stage is valid and pending, the value is written into the stage's next position (ld_stage+1), or into `gpr` if ld_stage = LD-1, and pend is cleared. A fill to a non-pending or invalid stage is ignored.
- fwd_sig_x[i] (combinational) = valid_i & ~pend_i & (idx_i == dq_x).
  - Priority is resolved by the consumer: the lowest i wins.
  - This block still asserts every matching bit.
  - dq_x == RIP_ADDR never matches.
- fwd_val[i] = val_i (combinational).
- Same-register writes: two stages may hold the same idx, and commits follow pipeline order. The GPR ends with the youngest value once all have drained.
- flush does not affect entries already captured; they drain and commit.
- Reset mid-operation: in-flight results are lost and the GPRs return to 0.
- Latency: a result captured at edge N commits at edge N+LD and is readable from `gpr` after it.

Optional Feature:
- FWD_SCOREBOARD_EN defined:
  - hazard = OR over stages of (valid & pend & idx matching any of dq_d/dq_s/dq_t).
  - This is registered-free combinational; decode uses it as stall.
- FWD_SCOREBOARD_EN undefined:
  - `hazard` port is absent.
  - Pending entries are simply not forwarded; decode correctness is the issuer's responsibility.

Test Plan:
- Reset release, no results for 10 cycles -> all gpr = 0, all fwd_sig_* = 0.
- res idx=3 val=0x1234 at cycle 0, dq_s=3 -> fwd_sig_s = 001, then 010, then 100 on successive cycles; gpr[3] = 0x1234 after edge 3; fwd_sig_s = 000 afterwards.
- Back-to-back writes to idx 5: values 0xA then 0xB, dq_d=5 -> fwd_sig_d shows two bits (e.g. 011); gpr[5] = 0xA then 0xB on consecutive cycles; final value 0xB.
- Result with flush=1, or idx=RIP_ADDR=16 -> no stage valid, no fwd_sig bit, gpr unchanged.
- Pending load to idx 7, ld_valid at stage 1 with ld_val=0xDEAD -> no fwd_sig_t while pending and hazard=1 with dq_t=7 (with FWD_SCOREBOARD_EN); after the fill, fwd_sig_t bit2 is set and gpr[7] = 0xDEAD at commit.
- rstn pulsed low mid-stream with 3 valid stages -> immediate clear; after release gpr[x] = 0 and no commits occur.

Source files
------------

// File: rtl/gpr_writeback_unit.sv
// Post-decode result tracker: shifts results through POST_DEC_LD stages, commits into the GPR file,
// and drives per-stage forwarding to decode. Define FWD_SCOREBOARD_EN to add the `hazard` stall output.
module gpr_writeback_unit #(
    parameter int POST_DEC_LD = 3,
    parameter int REG_W       = 64,
    parameter int REG_N       = 16,
    parameter int IDX_W       = 5,
    parameter int RIP_ADDR    = 16
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           res_valid,
    input  logic [IDX_W-1:0]               res_idx,
    input  logic [REG_W-1:0]               res_val,
    input  logic                           res_pend,
    input  logic                           ld_valid,
    input  logic [$clog2(POST_DEC_LD)-1:0] ld_stage,
    input  logic [REG_W-1:0]               ld_val,
    input  logic                           flush,
    input  logic [IDX_W-1:0]               dq_d,
    input  logic [IDX_W-1:0]               dq_s,
    input  logic [IDX_W-1:0]               dq_t,
    output logic [POST_DEC_LD-1:0]         fwd_sig_d,
    output logic [POST_DEC_LD-1:0]         fwd_sig_s,
    output logic [POST_DEC_LD-1:0]         fwd_sig_t,
    output logic [REG_W-1:0]               fwd_val [POST_DEC_LD],
    output logic [REG_W-1:0]               gpr [REG_N]
`ifdef FWD_SCOREBOARD_EN
    ,
    output logic                           hazard
`endif
);
    localparam int               GPR_AW  = $clog2(REG_N);
    localparam int               LAST    = POST_DEC_LD - 1;
    localparam logic [IDX_W-1:0] RIP_IDX = IDX_W'(RIP_ADDR);

    typedef struct packed {
        logic             valid;
        logic             pend;
        logic [IDX_W-1:0] idx;
        logic [REG_W-1:0] val;
    } stage_t;

    stage_t                 stg [POST_DEC_LD];
    stage_t                 cap;
    logic [POST_DEC_LD-1:0] fill_hit;
    logic                   commit_ok;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cap       = '0;
        cap.valid = res_valid & ~flush & (res_idx != RIP_IDX) & (32'(res_idx) < 32'(REG_N));
        cap.idx   = res_idx;
        cap.pend  = cap.valid & res_pend;
        cap.val   = cap.valid ? res_val : '0;

        fill_hit = '0;
        for (int i = 0; i < POST_DEC_LD; i++)
            fill_hit[i] = ld_valid & (32'(ld_stage) == 32'(i)) & stg[i].valid & stg[i].pend;

        commit_ok = stg[LAST].valid & ~stg[LAST].pend;
    end

    // Pending entries never forward; RIP never matches even if an index happens to alias.
    always_comb begin
        fwd_sig_d = '0;
        fwd_sig_s = '0;
        fwd_sig_t = '0;
        for (int i = 0; i < POST_DEC_LD; i++) begin
            fwd_val[i]   = stg[i].val;
            fwd_sig_d[i] = stg[i].valid & ~stg[i].pend & (stg[i].idx == dq_d) & (dq_d != RIP_IDX);
            fwd_sig_s[i] = stg[i].valid & ~stg[i].pend & (stg[i].idx == dq_s) & (dq_s != RIP_IDX);
            fwd_sig_t[i] = stg[i].valid & ~stg[i].pend & (stg[i].idx == dq_t) & (dq_t != RIP_IDX);
        end
    end

`ifdef FWD_SCOREBOARD_EN
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < POST_DEC_LD; i++)
            if (stg[i].valid & stg[i].pend &
                ((stg[i].idx == dq_d) | (stg[i].idx == dq_s) | (stg[i].idx == dq_t)))
                hazard = 1'b1;
    end
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the register file is architectural state that must read 0 after reset, so it is reset explicitly.
            for (int i = 0; i < POST_DEC_LD; i++) stg[i] <= '0;
            for (int r = 0; r < REG_N; r++)       gpr[r] <= '0;
        end else begin
            // NOTE: non-blocking assignments let every stage read its predecessor's pre-edge value.
            stg[0] <= cap;
            for (int i = 1; i < POST_DEC_LD; i++) begin
                stg[i] <= stg[i-1];
                if (fill_hit[i-1]) begin
                    stg[i].val  <= ld_val;
                    stg[i].pend <= 1'b0;
                end
            end
            // A fill landing on the oldest stage commits straight into the register file.
            if (commit_ok)
                gpr[stg[LAST].idx[GPR_AW-1:0]] <= stg[LAST].val;
            else if (fill_hit[LAST])
                gpr[stg[LAST].idx[GPR_AW-1:0]] <= ld_val;
        end
    end

    wb_pend_at_commit: assert property (@(posedge clk) disable iff (!rstn)
        !(stg[LAST].valid && stg[LAST].pend && !fill_hit[LAST]))
        else $error("wb_pend_at_commit: pending result dropped at commit, idx %0d", stg[LAST].idx);

endmodule

// File: tb/tb_gpr_writeback_unit.sv
// Self-checking bench for gpr_writeback_unit: directed vector table, reset sequences,
// and randomized traffic against a queue-based model of in-flight results.
module tb_gpr_writeback_unit;
    localparam int               LD    = 3;
    localparam int               REG_W = 64;
    localparam int               REG_N = 16;
    localparam int               IDX_W = 5;
    localparam int               SW    = $clog2(LD);
    localparam logic [IDX_W-1:0] RIP   = 5'd16;
    localparam int               NV    = 21;

    logic             clk = 1'b0;
    logic             rstn;
    logic             res_valid, res_pend, ld_valid, flush;
    logic [IDX_W-1:0] res_idx, dq_d, dq_s, dq_t;
    logic [REG_W-1:0] res_val, ld_val;
    logic [SW-1:0]    ld_stage;
    logic [LD-1:0]    fwd_sig_d, fwd_sig_s, fwd_sig_t;
    logic [REG_W-1:0] fwd_val [LD];
    logic [REG_W-1:0] gpr [REG_N];
`ifdef FWD_SCOREBOARD_EN
    logic             hazard;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gpr_writeback_unit #(
        .POST_DEC_LD(LD), .REG_W(REG_W), .REG_N(REG_N), .IDX_W(IDX_W), .RIP_ADDR(16)
    ) dut (
        .clk(clk), .rstn(rstn),
        .res_valid(res_valid), .res_idx(res_idx), .res_val(res_val), .res_pend(res_pend),
        .ld_valid(ld_valid), .ld_stage(ld_stage), .ld_val(ld_val), .flush(flush),
        .dq_d(dq_d), .dq_s(dq_s), .dq_t(dq_t),
        .fwd_sig_d(fwd_sig_d), .fwd_sig_s(fwd_sig_s), .fwd_sig_t(fwd_sig_t),
        .fwd_val(fwd_val), .gpr(gpr)
`ifdef FWD_SCOREBOARD_EN
        , .hazard(hazard)
`endif
    );

    task automatic check(input string name, input logic [REG_W-1:0] act, input logic [REG_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_gpr(input string name, input logic [REG_W-1:0] exp [REG_N]);
        int bad = -1;
        for (int r = 0; r < REG_N; r++)
            if (gpr[r] !== exp[r] && bad < 0) bad = r;
        if (bad < 0) check(name, gpr[0], exp[0]);
        else         check($sformatf("%s[%0d]", name, bad), gpr[bad], exp[bad]);
    endtask

    task automatic drive_idle();
        res_valid = 1'b0; res_idx = '0; res_val = '0; res_pend = 1'b0; flush = 1'b0;
        ld_valid  = 1'b0; ld_stage = '0; ld_val = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic             rv;
        logic [IDX_W-1:0] ri;
        logic [REG_W-1:0] rval;
        logic             rp, fl, lv;
        logic [SW-1:0]    ls;
        logic [REG_W-1:0] lval;
        logic [IDX_W-1:0] dd, ds, dt;
        logic [LD-1:0]    e_d, e_s, e_t;
        logic             e_hz;
        logic [IDX_W-1:0] g_idx;
        logic [REG_W-1:0] g_val;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(input logic rv, input int ri, input logic [REG_W-1:0] rval, input logic rp,
                                input logic fl, input logic lv, input int ls, input logic [REG_W-1:0] lval,
                                input int dd, input int ds, input int dt,
                                input logic [LD-1:0] ed, input logic [LD-1:0] es, input logic [LD-1:0] et,
                                input logic hz, input int gi, input logic [REG_W-1:0] gv);
        vec_t v;
        v.rv = rv; v.ri = IDX_W'(ri); v.rval = rval; v.rp = rp; v.fl = fl;
        v.lv = lv; v.ls = SW'(ls); v.lval = lval;
        v.dd = IDX_W'(dd); v.ds = IDX_W'(ds); v.dt = IDX_W'(dt);
        v.e_d = ed; v.e_s = es; v.e_t = et; v.e_hz = hz;
        v.g_idx = IDX_W'(gi); v.g_val = gv;
        return v;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic             valid, pend;
        logic [IDX_W-1:0] idx;
        logic [REG_W-1:0] val;
    } ent_t;

    ent_t             q [$];   // q[0] is the youngest in-flight slot
    logic [REG_W-1:0] gm [REG_N];
    logic [REG_W-1:0] zeros [REG_N];

    function automatic logic [LD-1:0] exp_sig(input logic [IDX_W-1:0] dq);
        logic [LD-1:0] r = '0;
        for (int i = 0; i < LD; i++)
            if (q[i].valid && !q[i].pend && q[i].idx == dq && dq != RIP) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic exp_hazard();
        logic h = 1'b0;
        for (int i = 0; i < LD; i++)
            if (q[i].valid && q[i].pend && (q[i].idx == dq_d || q[i].idx == dq_s || q[i].idx == dq_t)) h = 1'b1;
        return h;
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        ent_t e, c;
        int   ls = int'(ld_stage);
        if (ld_valid && ls < LD && q[ls].valid && q[ls].pend) begin
            e = q[ls]; e.val = ld_val; e.pend = 1'b0; q[ls] = e;
        end
        e = q.pop_back();
        if (e.valid && !e.pend) gm[int'(e.idx)] = e.val;
        c.valid = res_valid && !flush && res_idx != RIP && int'(res_idx) < REG_N;
        c.idx   = res_idx;
        c.pend  = c.valid && res_pend;
        c.val   = c.valid ? res_val : '0;
        q.push_front(c);
    endtask

    function automatic logic [IDX_W-1:0] rand_idx();
        int p = $urandom_range(0, 11);
        if (p == 10) return RIP;
        if (p == 11) return 5'd20;
        return IDX_W'($urandom_range(0, 7));
    endfunction

    initial begin
        for (int r = 0; r < REG_N; r++) zeros[r] = '0;

        vt[0]  = mk(1,  3, 64'h1234, 0, 0, 0, 0, 0,      0, 3, 0,  3'b000, 3'b000, 3'b000, 0,  3, 64'h0);
        vt[1]  = mk(0,  0, 0,        0, 0, 0, 0, 0,      0, 3, 0,  3'b000, 3'b001, 3'b000, 0,  3, 64'h0);
        vt[2]  = mk(0,  0, 0,        0, 0, 0, 0, 0,      0, 3, 0,  3'b000, 3'b010, 3'b000, 0,  3, 64'h0);
        vt[3]  = mk(0,  0, 0,        0, 0, 0, 0, 0,      0, 3, 0,  3'b000, 3'b100, 3'b000, 0,  3, 64'h1234);
        vt[4]  = mk(0,  0, 0,        0, 0, 0, 0, 0,      0, 3, 0,  3'b000, 3'b000, 3'b000, 0,  3, 64'h1234);
        vt[5]  = mk(1,  5, 64'hA,    0, 0, 0, 0, 0,      5, 0, 0,  3'b000, 3'b000, 3'b000, 0,  5, 64'h0);
        vt[6]  = mk(1,  5, 64'hB,    0, 0, 0, 0, 0,      5, 0, 0,  3'b001, 3'b000, 3'b000, 0,  5, 64'h0);
        vt[7]  = mk(0,  0, 0,        0, 0, 0, 0, 0,      5, 0, 0,  3'b011, 3'b000, 3'b000, 0,  5, 64'h0);
        vt[8]  = mk(0,  0, 0,        0, 0, 0, 0, 0,      5, 0, 0,  3'b110, 3'b000, 3'b000, 0,  5, 64'hA);
        vt[9]  = mk(0,  0, 0,        0, 0, 0, 0, 0,      5, 0, 0,  3'b100, 3'b000, 3'b000, 0,  5, 64'hB);
        vt[10] = mk(0,  0, 0,        0, 0, 0, 0, 0,      5, 0, 0,  3'b000, 3'b000, 3'b000, 0,  5, 64'hB);
        vt[11] = mk(1,  9, 64'h55,   0, 1, 0, 0, 0,      0, 0, 9,  3'b000, 3'b000, 3'b000, 0,  9, 64'h0);
        vt[12] = mk(1, 16, 64'h66,   0, 0, 0, 0, 0,      0, 0, 9,  3'b000, 3'b000, 3'b000, 0,  9, 64'h0);
        vt[13] = mk(1, 20, 64'h77,   0, 0, 0, 0, 0,      0, 0, 16, 3'b000, 3'b000, 3'b000, 0,  9, 64'h0);
        vt[14] = mk(0,  0, 0,        0, 0, 0, 0, 0,      0, 0, 20, 3'b000, 3'b000, 3'b000, 0,  0, 64'h0);
        vt[15] = mk(0,  0, 0,        0, 0, 0, 0, 0,      0, 0, 9,  3'b000, 3'b000, 3'b000, 0,  9, 64'h0);
        vt[16] = mk(1,  7, 64'h999,  1, 0, 0, 0, 0,      0, 0, 7,  3'b000, 3'b000, 3'b000, 0,  7, 64'h0);
        vt[17] = mk(0,  0, 0,        0, 0, 0, 0, 0,      0, 0, 7,  3'b000, 3'b000, 3'b000, 1,  7, 64'h0);
        vt[18] = mk(0,  0, 0,        0, 0, 1, 1, 64'hDEAD, 0, 0, 7, 3'b000, 3'b000, 3'b000, 1,  7, 64'h0);
        vt[19] = mk(0,  0, 0,        0, 0, 0, 0, 0,      0, 0, 7,  3'b000, 3'b000, 3'b100, 0,  7, 64'hDEAD);
        vt[20] = mk(0,  0, 0,        0, 0, 0, 0, 0,      0, 0, 7,  3'b000, 3'b000, 3'b000, 0,  7, 64'hDEAD);

        // ---- reset, then 10 idle cycles ----
        rstn = 1'b0;
        drive_idle();
        dq_d = 5'd0; dq_s = 5'd1; dq_t = 5'd2;
        #22 rstn = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check_gpr("idle gpr", zeros);
        check("idle sig_d", fwd_sig_d, '0);
        check("idle sig_s", fwd_sig_s, '0);
        check("idle sig_t", fwd_sig_t, '0);
        for (int i = 0; i < LD; i++) check($sformatf("idle fwd_val%0d", i), fwd_val[i], '0);
`ifdef FWD_SCOREBOARD_EN
        check("idle hazard", hazard, 1'b0);
`endif

        // ---- directed vectors ----
        for (int k = 0; k < NV; k++) begin
            res_valid = vt[k].rv; res_idx = vt[k].ri; res_val = vt[k].rval; res_pend = vt[k].rp;
            flush = vt[k].fl; ld_valid = vt[k].lv; ld_stage = vt[k].ls; ld_val = vt[k].lval;
            dq_d = vt[k].dd; dq_s = vt[k].ds; dq_t = vt[k].dt;
            #1;
            check($sformatf("vec%0d sig_d", k), fwd_sig_d, vt[k].e_d);
            check($sformatf("vec%0d sig_s", k), fwd_sig_s, vt[k].e_s);
            check($sformatf("vec%0d sig_t", k), fwd_sig_t, vt[k].e_t);
`ifdef FWD_SCOREBOARD_EN
            check($sformatf("vec%0d hazard", k), hazard, vt[k].e_hz);
`endif
            @(posedge clk);
            #1;
            check($sformatf("vec%0d gpr[%0d]", k, vt[k].g_idx), gpr[vt[k].g_idx[3:0]], vt[k].g_val);
        end

        // ---- reset pulsed with three valid stages in flight ----
        drive_idle();
        for (int k = 1; k <= 3; k++) begin
            res_valid = 1'b1; res_idx = IDX_W'(k); res_val = REG_W'(k * 'h11);
            @(posedge clk);
            #1;
        end
        drive_idle();
        dq_d = 5'd1; dq_s = 5'd2; dq_t = 5'd3;
        #1;
        check("pre-rst sig_d", fwd_sig_d, 3'b100);
        check("pre-rst sig_s", fwd_sig_s, 3'b010);
        check("pre-rst sig_t", fwd_sig_t, 3'b001);
        #1 rstn = 1'b0;
        #1;
        check("in-rst sig_d", fwd_sig_d, '0);
        check("in-rst sig_t", fwd_sig_t, '0);
        check("in-rst fwd_val0", fwd_val[0], '0);
        check_gpr("in-rst gpr", zeros);
        #2 rstn = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check_gpr("post-rst gpr", zeros);
        check("post-rst sig_s", fwd_sig_s, '0);

        // ---- randomized traffic against the model ----
        q.delete();
        for (int i = 0; i < LD; i++) q.push_back('{valid: 1'b0, pend: 1'b0, idx: '0, val: '0});
        for (int r = 0; r < REG_N; r++) gm[r] = '0;

        for (int cyc = 0; cyc < 400; cyc++) begin
            res_valid = ($urandom_range(0, 9) < 7);
            res_idx   = rand_idx();
            res_val   = {$urandom(), $urandom()};
            res_pend  = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 9) == 0);
            ld_val    = {$urandom(), $urandom()};
            if (q[LD-1].valid && q[LD-1].pend) begin
                ld_valid = 1'b1; ld_stage = SW'(LD - 1);
            end else begin
                ld_valid = ($urandom_range(0, 2) == 0); ld_stage = SW'($urandom_range(0, 3));
            end
            dq_d = rand_idx(); dq_s = rand_idx(); dq_t = rand_idx();
            #1;
            check($sformatf("rnd%0d sig_d", cyc), fwd_sig_d, exp_sig(dq_d));
            check($sformatf("rnd%0d sig_s", cyc), fwd_sig_s, exp_sig(dq_s));
            check($sformatf("rnd%0d sig_t", cyc), fwd_sig_t, exp_sig(dq_t));
            for (int i = 0; i < LD; i++) check($sformatf("rnd%0d fwd_val%0d", cyc, i), fwd_val[i], q[i].val);
`ifdef FWD_SCOREBOARD_EN
            check($sformatf("rnd%0d hazard", cyc), hazard, exp_hazard());
`endif
            check_gpr($sformatf("rnd%0d gpr", cyc), gm);
            @(posedge clk);
            model_step();
            #1;
        end
        drive_idle();
        repeat (LD) begin
            @(posedge clk);
            model_step();
            #1;
        end
        check_gpr("drained gpr", gm);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
